// File: rtl/frame_writer_if.sv
// Signal bundle between the frame writer, its pixel source, the render
// control logic and the SDRAM controller write port.
interface frame_writer_if;
    // render control
    logic         frame_flip;
    logic         start;
    logic         clear;
    logic [7:0]   clear_color;
    // pixel stream (raster order)
    logic         pix_valid;
    logic [7:0]   pix_data;
    logic         pix_ready;
    // SDRAM controller write port
    logic [21:0]  sdram_addr;
    logic [127:0] sdram_wdata;
    logic         sdram_wr;
    logic         sdram_ac;
    logic         sdram_Wait;
    // status
    logic         busy;
    logic         done;

    // The frame writer itself
    modport master (
        input  frame_flip, start, clear, clear_color,
        input  pix_valid, pix_data,
        output pix_ready,
        output sdram_addr, sdram_wdata, sdram_wr,
        input  sdram_ac, sdram_Wait,
        output busy, done
    );

    // Everything around it: render logic, pixel source, SDRAM controller
    modport slave (
        output frame_flip, start, clear, clear_color,
        output pix_valid, pix_data,
        input  pix_ready,
        input  sdram_addr, sdram_wdata, sdram_wr,
        output sdram_ac, sdram_Wait,
        input  busy, done
    );
endinterface

// File: rtl/frame_writer.sv
// Packs a raster-order stream of 8-bit palette indices into 128-bit words
// and writes them into the SDRAM back buffer (the one not on display), or
// fills the whole back buffer with one palette index in clear mode.
module frame_writer #(
    parameter logic [21:0] ADDR1          = 22'h100000,
    parameter logic [21:0] ADDR2          = 22'h200000,
    parameter int          WORDS_PER_LINE = 40,
    parameter int          LINES          = 480
) (
    input  logic           clock,
    input  logic           reset,
    frame_writer_if.master bus
);

    localparam int N     = WORDS_PER_LINE * LINES;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_WRITE,
        S_CLEAR_WR,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   word_idx_q, word_idx_d;
    logic [3:0]         pix_cnt_q, pix_cnt_d;
    logic [127:0]       pack_q, pack_d;
    logic [21:0]        base_q, base_d;

    logic [127:0]       clear_word;
    logic [15:0]        lane_sel;
    logic               pix_take;
    logic               wr_req;
    logic               wr_accept;
    logic               launch;
    logic               last_word;

    // Clear fill pattern and per-lane write select for the packer
    for (genvar gi = 0; gi < 16; gi++) begin : g_lane
        assign clear_word[gi*8 +: 8] = bus.clear_color;
        assign lane_sel[gi]          = (pix_cnt_q == 4'(gi));
    end

    // Handshake qualifiers; the request is withheld while the controller is busy
    always_comb begin
        pix_take  = (state_q == S_FILL) && bus.pix_valid;
        wr_req    = ((state_q == S_WRITE) || (state_q == S_CLEAR_WR)) && !bus.sdram_Wait;
        wr_accept = wr_req && bus.sdram_ac;
        launch    = ((state_q == S_IDLE) || (state_q == S_DONE)) && (bus.start || bus.clear);
        last_word = (word_idx_q == LAST_IDX);
    end

    // State register and datapath registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            word_idx_q <= '0;
            pix_cnt_q  <= '0;
            pack_q     <= '0;
            base_q     <= '0;
        end else begin
            state_q    <= state_d;
            word_idx_q <= word_idx_d;
            pix_cnt_q  <= pix_cnt_d;
            pack_q     <= pack_d;
            base_q     <= base_d;
        end
    end

    // Next-state logic; the buffer base is latched once per operation so
    // later frame_flip changes cannot steer writes into the displayed buffer
    always_comb begin
        state_d    = state_q;
        word_idx_d = word_idx_q;
        pix_cnt_d  = pix_cnt_q;
        pack_d     = pack_q;
        base_d     = base_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (launch) begin
                    word_idx_d = '0;
                    pix_cnt_d  = '0;
                    base_d     = bus.frame_flip ? ADDR2 : ADDR1;
                    if (bus.clear) begin
                        // clear takes priority over a simultaneous start
                        pack_d  = clear_word;
                        state_d = S_CLEAR_WR;
                    end else begin
                        state_d = S_FILL;
                    end
                end
            end
            S_FILL: begin
                if (pix_take) begin
                    for (int i = 0; i < 16; i++) begin
                        if (lane_sel[i]) begin
                            pack_d[i*8 +: 8] = bus.pix_data;
                        end
                    end
                    // 4-bit counter wraps to 0 after lane 15
                    pix_cnt_d = pix_cnt_q + 4'd1;
                    if (pix_cnt_q == 4'd15) begin
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                if (wr_accept) begin
                    if (last_word) begin
                        state_d = S_DONE;
                    end else begin
                        word_idx_d = word_idx_q + IDX_W'(1);
                        state_d    = S_FILL;
                    end
                end
            end
            S_CLEAR_WR: begin
                // pack register already holds the fill pattern; stream it out
                if (wr_accept) begin
                    if (last_word) begin
                        state_d = S_DONE;
                    end else begin
                        word_idx_d = word_idx_q + IDX_W'(1);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs: address and data come straight from registers, so they stay
    // stable for as long as a word waits for acceptance
    always_comb begin
        bus.pix_ready   = (state_q == S_FILL);
        bus.sdram_wr    = wr_req;
        bus.sdram_addr  = base_q + 22'(word_idx_q);
        bus.sdram_wdata = pack_q;
        bus.busy        = (state_q != S_IDLE) && (state_q != S_DONE);
        bus.done        = (state_q == S_DONE);
    end

endmodule

// File: tb/tb_frame_writer.sv
// Directed bench for frame_writer on a reduced frame (2 words x 3 lines).
// A small SDRAM responder and pixel source live in run_frame; expected
// addresses and data are computed from the raster pattern (x+y)&0xFF.
module tb_frame_writer;

    localparam int WPL   = 2;
    localparam int LNS   = 3;
    localparam int N     = WPL * LNS;
    localparam int PPL   = WPL * 16;
    localparam logic [21:0] A1 = 22'h100000;
    localparam logic [21:0] A2 = 22'h200000;

    logic clock;
    logic reset;
    int   vectors     = 0;
    int   miscompares = 0;
    logic [127:0] wlog [0:N-1];

    frame_writer_if bus ();

    frame_writer #(
        .ADDR1          (A1),
        .ADDR2          (A2),
        .WORDS_PER_LINE (WPL),
        .LINES          (LNS)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] pix_of(input int i);
        int x, y;
        x = i % PPL;
        y = i / PPL;
        return 8'((x + y) & 255);
    endfunction

    function automatic logic [127:0] word_of(input int k);
        logic [127:0] w;
        w = '0;
        for (int j = 0; j < 16; j++) w[j*8 +: 8] = pix_of(16 * k + j);
        return w;
    endfunction

    // one-cycle start/clear pulse, then confirm the operation is under way
    task automatic pulse(input string tag, input logic s, input logic c);
        @(negedge clock);
        bus.pix_valid = 1'b0;
        bus.start = s;
        bus.clear = c;
        @(negedge clock);
        bus.start = 1'b0;
        bus.clear = 1'b0;
        check({tag, "_done_drop"}, 128'(bus.done), 128'd0);
        check({tag, "_busy"},      128'(bus.busy), 128'd1);
    endtask

    // Cycle-by-cycle pixel source + SDRAM responder (ac one cycle after request).
    // abort_words < 0 runs to done; stall_word < 0 disables the Wait window.
    task automatic run_frame(input string name, input bit is_clear, input logic [21:0] base,
                             input logic [7:0] color, input bit rand_valid, input int stall_word,
                             input int abort_words, input bit flip_toggle, input bit mid_start);
        int nwr = 0, pix_idx = 0, req_cycles = 0, stall_left = 0, cyc = 0;
        bit pending = 0, stalled = 0, ready_seen = 0;
        logic [21:0]  saved_addr;
        logic [127:0] saved_data;
        logic [127:0] exp_data;
        saved_addr = '0;
        saved_data = '0;
        while (1) begin
            @(negedge clock);
            bus.start = 1'b0;
            bus.clear = 1'b0;
            bus.sdram_ac = 1'b0;
            cyc++;
            if (bus.done || nwr == abort_words) break;
            if (cyc > 3000) begin
                check({name, "_timeout_writes"}, 128'(nwr), 128'(N));
                break;
            end
            if (flip_toggle && cyc == 20) bus.frame_flip = ~bus.frame_flip;
            if (mid_start && cyc == 30) bus.start = 1'b1;
            bus.pix_valid  = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.pix_data   = pix_of(pix_idx);
            bus.sdram_Wait = (stall_left > 0);
            #1;
            if (bus.pix_ready) ready_seen = 1;
            if (bus.pix_valid && bus.pix_ready) pix_idx++;
            if (stall_left > 0) begin
                check({name, "_stall_wr"}, 128'(bus.sdram_wr), 128'd0);
                bus.sdram_ac = 1'b1;  // no request is up, so this must be ignored
                stall_left--;
            end else if (bus.sdram_wr) begin
                if (pending) begin
                    check({name, "_hold_addr"}, 128'(bus.sdram_addr), 128'(saved_addr));
                    check({name, "_hold_data"}, bus.sdram_wdata, saved_data);
                end else begin
                    pending    = 1;
                    saved_addr = bus.sdram_addr;
                    saved_data = bus.sdram_wdata;
                end
                req_cycles++;
                if (nwr == stall_word && !stalled) begin
                    stalled    = 1;
                    stall_left = 10;
                    req_cycles = 0;
                end else if (req_cycles >= 2) begin
                    bus.sdram_ac = 1'b1;
                    exp_data = is_clear ? {16{color}} : word_of(nwr);
                    check({name, "_addr"}, 128'(bus.sdram_addr), 128'(base + 22'(nwr)));
                    check({name, "_data"}, bus.sdram_wdata, exp_data);
                    $display("%s: write %0d addr %h data %h", name, nwr, bus.sdram_addr, bus.sdram_wdata);
                    if (nwr < N) wlog[nwr] = bus.sdram_wdata;
                    nwr++;
                    pending    = 0;
                    req_cycles = 0;
                end
            end else begin
                req_cycles = 0;
            end
        end
        bus.sdram_ac   = 1'b0;
        bus.sdram_Wait = 1'b0;
        if (abort_words < 0) begin
            check({name, "_nwrites"}, 128'(nwr), 128'(N));
            check({name, "_done"},    128'(bus.done), 128'd1);
            check({name, "_busy_end"}, 128'(bus.busy), 128'd0);
            if (is_clear) check({name, "_ready_seen"}, 128'(ready_seen), 128'd0);
        end
    endtask

    initial begin
        reset           = 1'b1;
        bus.frame_flip  = 1'b0;
        bus.start       = 1'b0;
        bus.clear       = 1'b0;
        bus.clear_color = 8'h00;
        bus.pix_valid   = 1'b0;
        bus.pix_data    = 8'h00;
        bus.sdram_ac    = 1'b0;
        bus.sdram_Wait  = 1'b0;

        // reset state
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("rst_wr",    128'(bus.sdram_wr),  128'd0);
        check("rst_addr",  128'(bus.sdram_addr), 128'd0);
        check("rst_wdata", bus.sdram_wdata,     128'd0);
        check("rst_busy",  128'(bus.busy),      128'd0);
        check("rst_done",  128'(bus.done),      128'd0);
        check("rst_ready", 128'(bus.pix_ready), 128'd0);

        // full frame into buffer 1
        bus.frame_flip = 1'b0;
        pulse("f1", 1'b1, 1'b0);
        run_frame("f1", 1'b0, A1, 8'h00, 1'b0, -1, -1, 1'b0, 1'b0);
        check("f1_word0",   wlog[0], 128'h0F0E0D0C0B0A09080706050403020100);
        check("f1_line1_b0", 128'(wlog[WPL][7:0]), 128'h01);

        // clear of buffer 2
        bus.frame_flip  = 1'b1;
        bus.clear_color = 8'h2A;
        pulse("clr", 1'b0, 1'b1);
        run_frame("clr", 1'b1, A2, 8'h2A, 1'b0, -1, -1, 1'b0, 1'b0);

        // controller Wait for 10 cycles during word 3
        bus.frame_flip = 1'b0;
        pulse("stall", 1'b1, 1'b0);
        run_frame("stall", 1'b0, A1, 8'h00, 1'b0, 3, -1, 1'b0, 1'b0);

        // frame_flip toggled mid-frame must not move the target buffer
        bus.frame_flip = 1'b0;
        pulse("flip", 1'b1, 1'b0);
        run_frame("flip", 1'b0, A1, 8'h00, 1'b0, -1, -1, 1'b1, 1'b0);

        // reset after 5 words, then a fresh frame from word 0
        bus.frame_flip = 1'b1;
        pulse("abort", 1'b1, 1'b0);
        run_frame("abort", 1'b0, A2, 8'h00, 1'b0, -1, 5, 1'b0, 1'b0);
        reset = 1'b1;
        @(negedge clock);
        check("abort_wr",   128'(bus.sdram_wr), 128'd0);
        check("abort_busy", 128'(bus.busy),     128'd0);
        check("abort_done", 128'(bus.done),     128'd0);
        reset = 1'b0;
        bus.frame_flip = 1'b0;
        pulse("restart", 1'b1, 1'b0);
        run_frame("restart", 1'b0, A1, 8'h00, 1'b0, -1, -1, 1'b0, 1'b0);

        // gappy pixel stream with a start pulse while busy
        bus.frame_flip = 1'b1;
        pulse("rand", 1'b1, 1'b0);
        run_frame("rand", 1'b0, A2, 8'h00, 1'b1, -1, -1, 1'b0, 1'b1);

        // start and clear together from DONE: clear wins
        bus.frame_flip  = 1'b0;
        bus.clear_color = 8'h5C;
        pulse("both", 1'b1, 1'b1);
        run_frame("both", 1'b1, A1, 8'h5C, 1'b1, -1, -1, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
